// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC register, issues single-beat reads to
// instruction memory and buffers fetched words in a 2-entry queue for decode.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        le_pc,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] entry_pc_q    [2];
  logic [31:0] entry_instr_q [2];

  logic        push;
  logic        pop;
  logic [1:0]  count_after_pop;

  // Queue storage carries no reset; count and pointers alone define validity.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == 1'(gi))) begin
        entry_pc_q[gi]    <= pc;
        entry_instr_q[gi] <= imem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    le_pc           = 1'b0;
    pc_next         = pc + 32'd4;
    imem_req        = 1'b0;
    imem_addr       = pc;
    if_valid        = 1'b0;
    if_instr        = entry_instr_q[rd_ptr_q];
    if_pc           = entry_pc_q[rd_ptr_q];
    pop             = 1'b0;
    push            = 1'b0;
    count_after_pop = count_q;

    if (!reset) begin
      imem_req = (state_q != IDLE);
      if_valid = (count_q != 2'd0);

      if (branch_taken) begin
        // Redirect wins over any push, pop or increment this cycle.
        le_pc    = 1'b1;
        pc_next  = {branch_target[31:2], 2'b00};
        count_d  = 2'd0;
        rd_ptr_d = 1'b0;
        wr_ptr_d = 1'b0;
        if ((state_q != IDLE) && !imem_ack) begin
          state_d = DROP;
        end else begin
          state_d = REQ;
        end
      end else begin
        pop             = if_valid && id_ready;
        push            = (state_q == REQ) && imem_ack;
        count_after_pop = count_q - {1'b0, pop};
        count_d         = count_after_pop + {1'b0, push};
        le_pc           = push;
        if (pop) begin
          rd_ptr_d = ~rd_ptr_q;
        end
        if (push) begin
          wr_ptr_d = ~wr_ptr_q;
        end

        case (state_q)
          IDLE: begin
            if (count_after_pop < 2'd2) begin
              state_d = REQ;
            end
          end
          REQ: begin
            if (imem_ack) begin
              state_d = (count_d < 2'd2) ? REQ : IDLE;
            end
          end
          DROP: begin
            // Data returned for the abandoned address is thrown away.
            if (imem_ack) begin
              state_d = REQ;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench acts as PC register and memory,
// and a queue-based reference model predicts every output each cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        le_pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .le_pc         (le_pc),
    .pc_next       (pc_next),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
  );

  always #5 clk = ~clk;

  // Reference model: busy = a fetch is outstanding, disc = its data must be dropped.
  logic        m_busy = 1'b0, n_busy = 1'b0;
  logic        m_disc = 1'b0, n_disc = 1'b0;
  logic [63:0] m_q[$];
  logic [63:0] n_q[$];
  logic        have_next = 1'b0;
  logic        e_req, e_valid, e_le;
  logic [31:0] e_pcn;
  logic [63:0] e_head;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    e_req   = !reset && m_busy;
    e_valid = !reset && (m_q.size() != 0);
    e_head  = (m_q.size() != 0) ? m_q[0] : 64'h0;
    e_le    = 1'b0;
    e_pcn   = branch_taken ? {branch_target[31:2], 2'b00} : pc + 32'd4;
    n_q     = m_q;
    n_busy  = m_busy;
    n_disc  = m_disc;
    if (reset) begin
      n_busy = 1'b0;
      n_disc = 1'b0;
      n_q.delete();
    end else if (branch_taken) begin
      e_le   = 1'b1;
      n_disc = m_busy && !imem_ack;
      n_busy = 1'b1;
      n_q.delete();
    end else begin
      if ((m_q.size() != 0) && id_ready) void'(n_q.pop_front());
      if (!m_busy) begin
        n_busy = (n_q.size() < 2);
      end else if (imem_ack) begin
        if (m_disc) begin
          n_disc = 1'b0;
        end else begin
          n_q.push_back({pc, imem_rdata});
          e_le   = 1'b1;
          n_busy = (n_q.size() < 2);
          $display("push pc=%h instr=%h queue=%0d", pc, imem_rdata, n_q.size());
        end
      end
    end
  endtask

  task automatic compare();
    chk1("imem_req", imem_req, e_req);
    if (e_req) chk32("imem_addr", imem_addr, pc);
    chk1("le_pc", le_pc, e_le);
    if (!(reset && branch_taken)) chk32("pc_next", pc_next, e_pcn);
    chk1("if_valid", if_valid, e_valid);
    if (e_valid) begin
      chk32("if_pc", if_pc, e_head[63:32]);
      chk32("if_instr", if_instr, e_head[31:0]);
    end
  endtask

  // One clock: commit last cycle's model state, drive new inputs, check mid-cycle.
  task automatic step(input logic rst, input logic ack, input logic rdy,
                      input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    if (have_next) begin
      m_busy = n_busy;
      m_disc = n_disc;
      m_q    = n_q;
      if (e_le) pc = e_pcn;
    end
    reset         = rst;
    imem_ack      = ack;
    id_ready      = rdy;
    branch_taken  = br;
    branch_target = tgt;
    imem_rdata    = $urandom;
    @(negedge clk);
    model_eval();
    compare();
    have_next = 1'b1;
  endtask

  initial begin
    // Reset with other inputs active
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_le", le_pc, 1'b0);
    chk1("rst_valid", if_valid, 1'b0);

    // Streaming
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk1("idle_req", imem_req, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk32("stream_pcn0", pc_next, 32'h4);
    chk1("stream_le0", le_pc, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk32("stream_pcn1", pc_next, 32'h8);
    chk32("stream_ifpc0", if_pc, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk32("stream_pcn2", pc_next, 32'hC);
    chk32("stream_ifpc1", if_pc, 32'h4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk32("stream_ifpc2", if_pc, 32'h8);

    // Redirect coincident with ack and pop, then wrap-around
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD);
    chk32("redir_pcn", pc_next, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk1("flush_valid", if_valid, 1'b0);
    chk32("wrap_pcn", pc_next, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h10);
    chk32("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
    chk32("redir2_pcn", pc_next, 32'h10);

    // Redirect with an outstanding request
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
    chk32("drop_addr", imem_addr, 32'h10);
    chk32("drop_pcn", pc_next, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk32("drop_wait_addr", imem_addr, 32'h100);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk1("drop_ack_le", le_pc, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk32("after_drop_pcn", pc_next, 32'h104);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk32("after_drop_ifpc", if_pc, 32'h100);

    // Reset mid-DROP
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk1("rst_drop_req", imem_req, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk1("post_rst_req", imem_req, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk1("resume_req", imem_req, 1'b1);
    chk32("resume_addr", imem_addr, 32'h200);

    // Backpressure
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk1("full_req", imem_req, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk32("bp_pop_pc", if_pc, 32'h200);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk1("bp_reissue_req", imem_req, 1'b1);
    chk32("bp_reissue_addr", imem_addr, 32'h208);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 2),
           ($urandom_range(99) < 60),
           ($urandom_range(99) < 60),
           ($urandom_range(99) < 10),
           ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
